// File: rtl/vec_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_ram_pkg
// Description : Shared constants and helpers for the dual-port vector RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lat(input int out_reg);
        return 1 + out_reg;
    endfunction

    function automatic int rsp_depth(input int out_reg);
        return lat(out_reg) + 1;
    endfunction

    // Byte-lane merge: the new byte wins when its enable is set.
    function automatic logic [7:0] merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vec_ram_rsp_fifo
// Description : Fall-through response FIFO; input bypasses storage when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_ram_rsp_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(DEPTH - 1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE  = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty   = (r_count == '0);
    assign out_valid = !w_empty || in_valid;
    assign out_data  = !w_empty ? r_mem[r_rd_ptr] : (in_valid ? in_data : '0);

    // Only park the input when it cannot leave directly this cycle.
    assign w_push = in_valid && !(w_empty && out_ready);
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + C_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_ram_dp.sv
`default_nettype none
// ============================================================================
// Module      : vec_ram_dp
// Description : Simple-dual-port byte-enable vector RAM with credited reads.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_ram_dp
    import vec_ram_pkg::*;
#(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [DATA_W/8-1:0]  wr_be_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_W-1:0]    rsp_data_o,
    output logic                 rsp_err_o
);

    localparam int C_BE_W      = be_w(DATA_W);
    localparam int C_LAT       = lat(OUT_REG);
    localparam int C_RSP_DEPTH = rsp_depth(OUT_REG);
    localparam int C_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CRD_W     = $clog2(C_RSP_DEPTH + 1);
    localparam logic [C_CRD_W-1:0] C_CRD_MAX = C_CRD_W'(C_RSP_DEPTH);
    localparam logic [C_CRD_W-1:0] C_CRD_ONE = C_CRD_W'(1);

    generate
        if ((DATA_W % 8) != 0) begin : g_chk_data_w
            $error("vec_ram_dp: DATA_W must be a multiple of 8");
        end
        if (DEPTH > (2 ** ADDR_W)) begin : g_chk_depth
            $error("vec_ram_dp: DEPTH exceeds address space");
        end
        if (C_LAT < 1) begin : g_chk_lat
            $error("vec_ram_dp: invalid OUT_REG");
        end
    endgenerate

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               r_wr_ready;
    logic               r_rd_ready;
    logic [C_CRD_W-1:0] r_credits;
    logic [C_CRD_W-1:0] w_credits_nxt;

    logic               w_wr_fire;
    logic               w_rd_fire;
    logic               w_wr_in_range;
    logic               w_rd_in_range;
    logic [C_IDX_W-1:0] w_wr_idx;
    logic [C_IDX_W-1:0] w_rd_idx;
    logic [DATA_W-1:0]  w_rd_old;
    logic [DATA_W-1:0]  w_rd_word;

    logic               r_p0_valid;
    logic [DATA_W-1:0]  r_p0_data;
    logic               r_p0_err;
    logic               w_pipe_valid;
    logic [DATA_W-1:0]  w_pipe_data;
    logic               w_pipe_err;

    logic [DATA_W:0]    w_fifo_out;
    logic               w_rsp_valid;
    logic               w_rsp_pop;

    assign wr_ready_o = r_wr_ready;
    assign rd_ready_o = r_rd_ready;

    assign w_wr_fire     = wr_valid_i && r_wr_ready;
    assign w_rd_fire     = rd_valid_i && r_rd_ready;
    assign w_wr_in_range = (32'(wr_addr_i) < DEPTH);
    assign w_rd_in_range = (32'(rd_addr_i) < DEPTH);
    assign w_wr_idx      = wr_addr_i[C_IDX_W-1:0];
    assign w_rd_idx      = rd_addr_i[C_IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (w_wr_fire && w_wr_in_range) begin
            for (int k = 0; k < C_BE_W; k++) begin
                if (wr_be_i[k]) begin
                    r_mem[w_wr_idx][8*k +: 8] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

    assign w_rd_old = r_mem[w_rd_idx];

    // The array read samples pre-write contents; new-data mode merges the
    // concurrent write lanes in front of the pipeline.
    generate
        if (RDW_MODE == RDW_NEW) begin : g_rdw_new
            logic w_rdw_hit;
            assign w_rdw_hit = w_wr_fire && w_rd_fire && w_wr_in_range &&
                               w_rd_in_range && (wr_addr_i == rd_addr_i);
            for (genvar k = 0; k < C_BE_W; k++) begin : g_lane
                assign w_rd_word[8*k +: 8] = merge(w_rd_old[8*k +: 8],
                                                   wr_data_i[8*k +: 8],
                                                   w_rdw_hit && wr_be_i[k]);
            end
        end else begin : g_rdw_old
            assign w_rd_word = w_rd_old;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p0_valid <= 1'b0;
            r_p0_data  <= '0;
            r_p0_err   <= 1'b0;
        end else begin
            r_p0_valid <= w_rd_fire;
            r_p0_data  <= (w_rd_fire && w_rd_in_range) ? w_rd_word : '0;
            r_p0_err   <= w_rd_fire && !w_rd_in_range;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_p1_valid;
            logic [DATA_W-1:0] r_p1_data;
            logic              r_p1_err;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_p1_valid <= 1'b0;
                    r_p1_data  <= '0;
                    r_p1_err   <= 1'b0;
                end else begin
                    r_p1_valid <= r_p0_valid;
                    r_p1_data  <= r_p0_data;
                    r_p1_err   <= r_p0_err;
                end
            end
            assign w_pipe_valid = r_p1_valid;
            assign w_pipe_data  = r_p1_data;
            assign w_pipe_err   = r_p1_err;
        end else begin : g_no_out_reg
            assign w_pipe_valid = r_p0_valid;
            assign w_pipe_data  = r_p0_data;
            assign w_pipe_err   = r_p0_err;
        end
    endgenerate

    vec_ram_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (C_RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (w_pipe_valid),
        .in_data   ({w_pipe_err, w_pipe_data}),
        .out_valid (w_rsp_valid),
        .out_ready (rsp_ready_i),
        .out_data  (w_fifo_out)
    );

    assign rsp_valid_o = w_rsp_valid;
    assign rsp_data_o  = w_fifo_out[DATA_W-1:0];
    assign rsp_err_o   = w_fifo_out[DATA_W];
    assign w_rsp_pop   = w_rsp_valid && rsp_ready_i;

    // Credits bound in-flight plus buffered responses to the FIFO depth.
    always_comb begin
        w_credits_nxt = r_credits;
        unique case ({w_rd_fire, w_rsp_pop})
            2'b10:   w_credits_nxt = r_credits - C_CRD_ONE;
            2'b01:   w_credits_nxt = r_credits + C_CRD_ONE;
            default: w_credits_nxt = r_credits;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credits  <= C_CRD_MAX;
            r_rd_ready <= 1'b0;
            r_wr_ready <= 1'b0;
        end else begin
            r_credits  <= w_credits_nxt;
            r_rd_ready <= (w_credits_nxt != '0);
            r_wr_ready <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_ram_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_ram_dp
// Description : Directed bench; u0 = OUT_REG0/RDW old/DEPTH 1000,
//               u1 = OUT_REG1/RDW new/DEPTH 1024, sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_ram_dp;

    localparam logic [255:0] D1 =
        256'hDEADBEEFCAFEBABE112233445566778899AABBCCDDEEFF0011223344556677;
    localparam logic [255:0] ALL_FF = {256{1'b1}};
    localparam logic [255:0] PAT_A  = {8{32'hA5A55A5A}};
    localparam logic [255:0] PAT_B  = {8{32'h3C3CC3C3}};
    localparam logic [255:0] PAT_P  = {8{32'h0BADF00D}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_valid = 1'b0;
    logic [9:0]   wr_addr = '0;
    logic [31:0]  wr_be = '0;
    logic [255:0] wr_data = '0;
    logic         rd_valid = 1'b0;
    logic [9:0]   rd_addr = '0;
    logic         rsp_ready = 1'b1;

    logic         u0_wr_ready, u0_rd_ready, u0_rsp_valid, u0_rsp_err;
    logic [255:0] u0_rsp_data;
    logic         u1_wr_ready, u1_rd_ready, u1_rsp_valid, u1_rsp_err;
    logic [255:0] u1_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vec_ram_dp #(.DATA_W(256), .ADDR_W(10), .DEPTH(1000), .OUT_REG(0), .RDW_MODE(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(u0_wr_ready), .wr_addr_i(wr_addr),
        .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_valid_i(rd_valid), .rd_ready_o(u0_rd_ready), .rd_addr_i(rd_addr),
        .rsp_valid_o(u0_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(u0_rsp_data), .rsp_err_o(u0_rsp_err)
    );

    vec_ram_dp #(.DATA_W(256), .ADDR_W(10), .DEPTH(1024), .OUT_REG(1), .RDW_MODE(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(u1_wr_ready), .wr_addr_i(wr_addr),
        .wr_be_i(wr_be), .wr_data_i(wr_data),
        .rd_valid_i(rd_valid), .rd_ready_o(u1_rd_ready), .rd_addr_i(rd_addr),
        .rsp_valid_o(u1_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(u1_rsp_data), .rsp_err_o(u1_rsp_err)
    );

    function automatic logic [255:0] pat(input int i);
        logic [31:0] w;
        if (i == 1) return D1;
        w = 32'h50607080 + 32'(i) * 32'h01010101;
        return {8{w}};
    endfunction

    // One access cycle (optional write and/or read), then collect the first
    // response of each DUT; latency is counted in cycles after the accept cycle.
    task automatic do_access(
        input  logic do_wr, input logic [9:0] waddr, input logic [31:0] be,
        input  logic [255:0] wdata, input logic do_rd, input logic [9:0] raddr,
        output logic [255:0] d0, output logic e0, output int l0,
        output logic [255:0] d1, output logic e1, output int l1
    );
        d0 = '0; e0 = 1'b0; l0 = -1;
        d1 = '0; e1 = 1'b0; l1 = -1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wr_valid = do_wr; wr_addr = waddr; wr_be = be; wr_data = wdata;
        rd_valid = do_rd; rd_addr = raddr;
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        if (do_rd) begin
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (l0 < 0 && u0_rsp_valid) begin l0 = k; d0 = u0_rsp_data; e0 = u0_rsp_err; end
                if (l1 < 0 && u1_rsp_valid) begin l1 = k; d1 = u1_rsp_data; e1 = u1_rsp_err; end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_tests++; if ({u0_wr_ready, u1_wr_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 00", {u0_wr_ready, u1_wr_ready}); end
        n_tests++; if ({u0_rd_ready, u1_rd_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_ready got %b exp 00", {u0_rd_ready, u1_rd_ready}); end
        n_tests++; if ({u0_rsp_valid, u1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", {u0_rsp_valid, u1_rsp_valid}); end
        n_tests++; if ((u0_rsp_data | u1_rsp_data) !== 256'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", u0_rsp_data | u1_rsp_data); end
        n_tests++; if ({u0_rsp_err, u1_rsp_err} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 00", {u0_rsp_err, u1_rsp_err}); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if ({u0_wr_ready, u1_wr_ready} !== 2'b11) begin n_fail++; $display("FAIL post_reset_wr_ready got %b exp 11", {u0_wr_ready, u1_wr_ready}); end
        n_tests++; if ({u0_rd_ready, u1_rd_ready} !== 2'b11) begin n_fail++; $display("FAIL post_reset_rd_ready got %b exp 11", {u0_rd_ready, u1_rd_ready}); end
    endtask

    task automatic test_full_write();
        logic [255:0] d0, d1; logic e0, e1; int l0, l1;
        do_access(1'b1, 10'd1, 32'hFFFFFFFF, D1, 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        do_access(1'b0, 10'd0, 32'h0, 256'h0, 1'b1, 10'd1, d0, e0, l0, d1, e1, l1);
        n_tests++; if (l0 !== 1) begin n_fail++; $display("FAIL full_lat_u0 got %0d exp 1", l0); end
        n_tests++; if (l1 !== 2) begin n_fail++; $display("FAIL full_lat_u1 got %0d exp 2", l1); end
        n_tests++; if (d0 !== D1) begin n_fail++; $display("FAIL full_data_u0 got %h exp %h", d0, D1); end
        n_tests++; if (d1 !== D1) begin n_fail++; $display("FAIL full_data_u1 got %h exp %h", d1, D1); end
        n_tests++; if ({e0, e1} !== 2'b00) begin n_fail++; $display("FAIL full_err got %b exp 00", {e0, e1}); end
    endtask

    task automatic test_partial_write();
        logic [255:0] d0, d1, exp_d; logic e0, e1; int l0, l1;
        exp_d = {{192{1'b1}}, 64'h1122334455667788};
        do_access(1'b1, 10'd2, 32'hFFFFFFFF, ALL_FF, 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        do_access(1'b1, 10'd2, 32'h000000FF, {192'h0, 64'h1122334455667788}, 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        do_access(1'b0, 10'd0, 32'h0, 256'h0, 1'b1, 10'd2, d0, e0, l0, d1, e1, l1);
        n_tests++; if (d0 !== exp_d) begin n_fail++; $display("FAIL partial_u0 got %h exp %h", d0, exp_d); end
        n_tests++; if (d1 !== exp_d) begin n_fail++; $display("FAIL partial_u1 got %h exp %h", d1, exp_d); end
    endtask

    task automatic test_rdw();
        logic [255:0] d0, d1, mrg; logic e0, e1; int l0, l1;
        mrg = {PAT_A[255:128], PAT_B[127:0]};
        do_access(1'b1, 10'd3, 32'hFFFFFFFF, PAT_A, 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        do_access(1'b1, 10'd3, 32'h0000FFFF, PAT_B, 1'b1, 10'd3, d0, e0, l0, d1, e1, l1);
        n_tests++; if (d0 !== PAT_A) begin n_fail++; $display("FAIL rdw_old_u0 got %h exp %h", d0, PAT_A); end
        n_tests++; if (d1 !== mrg) begin n_fail++; $display("FAIL rdw_new_u1 got %h exp %h", d1, mrg); end
        do_access(1'b0, 10'd0, 32'h0, 256'h0, 1'b1, 10'd3, d0, e0, l0, d1, e1, l1);
        n_tests++; if (d0 !== mrg) begin n_fail++; $display("FAIL rdw_after_u0 got %h exp %h", d0, mrg); end
        n_tests++; if (d1 !== mrg) begin n_fail++; $display("FAIL rdw_after_u1 got %h exp %h", d1, mrg); end
    endtask

    task automatic test_backpressure();
        logic [255:0] d0, d1; logic e0, e1; int l0, l1;
        int nacc, nrsp, gaps; logic acc, started;
        for (int i = 0; i < 5; i++) begin
            do_access(1'b1, 10'(i), 32'hFFFFFFFF, pat(i), 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd0; nacc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); acc = u0_rd_ready;
            @(posedge clk); #1;
            if (acc) begin nacc++; rd_addr = rd_addr + 10'd1; end
        end
        @(negedge clk);
        n_tests++; if (nacc !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d exp 2", nacc); end
        n_tests++; if (u0_rd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rd_ready_low got %b exp 0", u0_rd_ready); end
        @(posedge clk); #1;
        rsp_ready = 1'b1; nrsp = 0; gaps = 0; started = 1'b0;
        for (int c = 0; c < 15 && nrsp < 5; c++) begin
            @(negedge clk);
            acc = rd_valid && u0_rd_ready;
            if (u0_rsp_valid) begin
                n_tests++;
                if (u0_rsp_data !== pat(nrsp)) begin n_fail++; $display("FAIL bp_rsp%0d got %h exp %h", nrsp, u0_rsp_data, pat(nrsp)); end
                nrsp++; started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            @(posedge clk); #1;
            if (acc && rd_valid) begin
                rd_addr = rd_addr + 10'd1;
                if (rd_addr == 10'd5) rd_valid = 1'b0;
            end
        end
        rd_valid = 1'b0;
        n_tests++; if (nrsp !== 5) begin n_fail++; $display("FAIL bp_rsp_count got %0d exp 5", nrsp); end
        n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL bp_gaps got %0d exp 0", gaps); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_tests++; if (u0.r_credits !== 2'd2) begin n_fail++; $display("FAIL bp_credits got %0d exp 2", u0.r_credits); end
        n_tests++; if (u0_rd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rd_ready_back got %b exp 1", u0_rd_ready); end
    endtask

    task automatic test_out_of_range();
        logic [255:0] d0, d1; logic e0, e1; int l0, l1;
        do_access(1'b1, 10'd999, 32'hFFFFFFFF, PAT_P, 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        do_access(1'b1, 10'd1000, 32'hFFFFFFFF, ALL_FF, 1'b0, 10'd0, d0, e0, l0, d1, e1, l1);
        do_access(1'b0, 10'd0, 32'h0, 256'h0, 1'b1, 10'd1000, d0, e0, l0, d1, e1, l1);
        n_tests++; if (d0 !== 256'h0) begin n_fail++; $display("FAIL oor_data_u0 got %h exp 0", d0); end
        n_tests++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL oor_err_u0 got %b exp 1", e0); end
        n_tests++; if (l0 !== 1) begin n_fail++; $display("FAIL oor_lat_u0 got %0d exp 1", l0); end
        n_tests++; if ({d1, e1} !== {ALL_FF, 1'b0}) begin n_fail++; $display("FAIL inrange1000_u1 got %h/%b exp %h/0", d1, e1, ALL_FF); end
        do_access(1'b0, 10'd0, 32'h0, 256'h0, 1'b1, 10'd999, d0, e0, l0, d1, e1, l1);
        n_tests++; if ({d0, e0} !== {PAT_P, 1'b0}) begin n_fail++; $display("FAIL a999_u0 got %h/%b exp %h/0", d0, e0, PAT_P); end
        n_tests++; if ({d1, e1} !== {PAT_P, 1'b0}) begin n_fail++; $display("FAIL a999_u1 got %h/%b exp %h/0", d1, e1, PAT_P); end
    endtask

    task automatic test_reset_mid_op();
        logic [255:0] d0, d1; logic e0, e1; int l0, l1; int seen;
        @(posedge clk); #1;
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'd1;
        repeat (3) begin @(posedge clk); #1; end
        rd_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (u1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", u1_rsp_valid); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if ({u0_rsp_valid, u1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_rsp_valid got %b exp 00", {u0_rsp_valid, u1_rsp_valid}); end
        n_tests++; if ({u0_rd_ready, u1_rd_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_rd_ready got %b exp 00", {u0_rd_ready, u1_rd_ready}); end
        n_tests++; if ((u0_rsp_data | u1_rsp_data) !== 256'h0) begin n_fail++; $display("FAIL mid_rsp_data got %h exp 0", u0_rsp_data | u1_rsp_data); end
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0; rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (u0_rsp_valid || u1_rsp_valid) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mid_stale_rsp got %0d exp 0", seen); end
        n_tests++; if ({u0_rd_ready, u1_rd_ready} !== 2'b11) begin n_fail++; $display("FAIL mid_rd_ready_back got %b exp 11", {u0_rd_ready, u1_rd_ready}); end
        n_tests++; if ({u0.r_credits, u1.r_credits} !== {2'd2, 2'd3}) begin n_fail++; $display("FAIL mid_credits got %0d/%0d exp 2/3", u0.r_credits, u1.r_credits); end
        do_access(1'b0, 10'd0, 32'h0, 256'h0, 1'b1, 10'd1, d0, e0, l0, d1, e1, l1);
        n_tests++; if ({d0, l0} !== {D1, 32'sd1}) begin n_fail++; $display("FAIL mid_read_u0 got %h lat %0d exp %h lat 1", d0, l0, D1); end
        n_tests++; if ({d1, l1} !== {D1, 32'sd2}) begin n_fail++; $display("FAIL mid_read_u1 got %h lat %0d exp %h lat 2", d1, l1, D1); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_write();
        test_rdw();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vec_ram_dp.md
Name: vec_ram_dp

Overview:
Parametrised simple-dual-port vector RAM with byte-enable writes. It is the successor to the single-port native vector RAM: one write port and one independent read port, each with a valid/ready handshake. Reads go through a configurable pipeline and a credit-controlled response buffer, so a vector engine can stall on rsp_ready_i without losing data. It adds a selectable read-during-write policy and out-of-range address reporting.

Parameters:
DATA_W, 256, word width in bits; must be a multiple of 8.
ADDR_W, 10, address port width.
DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_W.
OUT_REG, 0, 1 adds an output register stage after the array read.
RDW_MODE, 0, same-address read/write in the same cycle: 0 returns old data, 1 returns new data merged per byte enable.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
wr_valid_i  in  1  write request valid
wr_ready_o  out  1  write request ready
wr_addr_i  in  ADDR_W  write word address
wr_be_i  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k]
wr_data_i  in  DATA_W  write data
rd_valid_i  in  1  read request valid
rd_ready_o  out  1  read request ready; registered, with no combinational path from rsp_ready_i
rd_addr_i  in  ADDR_W  read word address
rsp_valid_o  out  1  read response valid
rsp_ready_i  in  1  read response accepted
rsp_data_o  out  DATA_W  read data; 0 when rsp_valid_o=0
rsp_err_o  out  1  response came from an out-of-range address; 0 when rsp_valid_o=0

Behaviour:
- Derived constants: LAT = 1+OUT_REG; RSP_DEPTH = LAT+1.
- Reset (async assert, sync release effect):
  - wr_ready_o=0, rd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0.
  - Pipeline valid bits cleared; FIFO pointers and count cleared; credits=RSP_DEPTH.
  - Array contents are not reset and are retained across reset.
- After reset: wr_ready_o=1 constantly. rd_ready_o = (credits != 0).
- Write: on a cycle with wr_valid_i & wr_ready_o, bytes with wr_be_i[k]=1 are written at the clock edge. Bytes with be=0 are unchanged. wr_be_i=0 is a legal no-op.
- Read accept at cycle t (rd_valid_i & rd_ready_o):
  - The array is read at the edge ending cycle t.
  - The data is presented at the response interface in cycle t+LAT.
- Response FIFO (RSP_DEPTH entries), fall-through:
  - When the FIFO is empty, pipeline output drives rsp_* directly in the same cycle.
  - If rsp_ready_i=0, the pipeline output is pushed into the FIFO.
  - Responses leave strictly in request order; none are lost or duplicated.
- Credits:
  - Decrement by 1 on a read accept; increment by 1 on a response pop (rsp_valid_o & rsp_ready_i).
  - A simultaneous accept and pop leaves credits unchanged.
  - Credits never exceed RSP_DEPTH or go below 0.
  - Back-to-back reads with rsp_ready_i held at 1 sustain 1 response per cycle.
- Read-during-write (same cycle, same in-range address, both handshakes fire):
  - RDW_MODE=0: response returns the pre-write word.
  - RDW_MODE=1: response returns the pre-write word with enabled bytes replaced by wr_data_i.
- Ordering across cycles: a write accepted in a cycle before a read's accept cycle is always visible to that read. A write accepted after the read's accept cycle is never visible to it.
- Out of range (addr >= DEPTH):
  - Write: dropped, array unchanged.
  - Read: still consumes a credit and returns rsp_data_o=0, rsp_err_o=1, with normal latency.
  - Out-of-range addresses never take part in read-during-write bypass.
- Reset asserted mid-operation: all in-flight and buffered responses are discarded, and no stale response appears after release.

Decomposition:
- vec_ram_pkg holds:
  - BE_W = DATA_W/8
  - function lat(OUT_REG)
  - function rsp_depth(OUT_REG)
  - RDW_OLD=0 and RDW_NEW=1 constants
  - a byte-merge function merge(old, new, be)
- One sub-module, vec_ram_rsp_fifo: a parametrised fall-through FIFO of width DATA_W+1 (data plus err) and depth RSP_DEPTH, with async active-high reset.
- The array, RDW bypass, pipeline and credit counter stay in vec_ram_dp.

Test Plan:
1. Full write: addr 1, wr_data=256'hDEADBEEFCAFEBABE112233445566778899AABBCCDDEEFF0011223344556677, be=32'hFFFFFFFF; then read addr 1 -> rsp_valid_o exactly LAT cycles after accept, data matches, rsp_err_o=0. Run with OUT_REG=0 and OUT_REG=1.
2. Partial write: addr 2 preloaded with all-FF; write be=32'h000000FF, data low 64 bits 64'h1122334455667788 -> read returns upper 24 bytes 0xFF and low 64 bits 1122334455667788.
3. Read-during-write: addr 3 holds pattern A; in the same cycle write pattern B with be=32'h0000FFFF and read addr 3 -> RDW_MODE=0 returns A; RDW_MODE=1 returns A with low 16 bytes taken from B. A read issued in the following cycle returns the merged word in both modes.
4. Backpressure: rsp_ready_i=0, rd_valid_i held for addrs 0..4 with OUT_REG=0 -> exactly 2 accepts, then rd_ready_o=0. Raise rsp_ready_i -> responses for addrs 0..4 arrive in order with no gaps once streaming, and credits return to 2.
5. Out of range, DEPTH=1000: write addr 1000 with all-FF, then read addrs 1000 and 999 -> addr 1000 returns data 0, err=1; addr 999 returns its prior contents, err=0.
6. Reset mid-operation: 2 reads in flight plus 1 buffered response, then assert rst_i asynchronously (between clock edges) -> rsp_valid_o and rd_ready_o drop at once. After release: no response emitted, rd_ready_o=1 (credits=RSP_DEPTH), and a subsequent read of addr 1 returns the test 1 data.
